// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
// Includes the state encoding, fixed restart vectors and default INTACK wait count.
package intr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    CLR,
    PUSH,
    VLO,
    VHI,
    LOAD
  } intr_state_t;

  localparam logic [15:0] NMI_VEC = 16'h0066;
  localparam logic [15:0] IM1_VEC = 16'h0038;

  localparam int ACK_WAITS_DEFAULT = 2;

endpackage

// File: rtl/intack_wait_cnt.sv
// INTACK wait-state down-counter: loads on entry to ACK and reports expiry at zero.
// Takes one cycle from load to the first count; a running count holds at zero until the next load.
module intack_wait_cnt (
  input  logic       clk,
  input  logic       nreset,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       en,
  output logic       expired
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 3'd0)) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign expired = (cnt == 3'd0);

endmodule

// File: rtl/intr_ack_seq.sv
// Interrupt acknowledge sequencer: NMI/INT entry, IFF clear, PC push, IM2 vector fetch, PC load.
// Push and reads wait on push_done/bus_ready. Macro INTR_IM0_EN enables IM0 opcode injection.
module intr_ack_seq
  import intr_pkg::*;
#(
  parameter int ACK_WAITS = ACK_WAITS_DEFAULT
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        instr_done,
  input  logic        in_nmi,
  input  logic        in_intr,
  input  logic        im1,
  input  logic        im2,
  input  logic [7:0]  i_reg,
  input  logic [7:0]  db,
  input  logic        bus_ready,
  input  logic        push_done,
  output logic        busy,
  output logic        ctl_no_ints,
  output logic        intack,
  output logic        clr_iff1,
  output logic        clr_iff2,
  output logic        push_req,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  output logic        pc_load,
  output logic [15:0] pc_vec,
  output logic [7:0]  im0_op,
  output logic        im0_valid
);

  localparam logic [2:0] WAITS = ACK_WAITS[2:0];

  intr_state_t state_q, state_d;
  logic        nmi_q, im2_q, im0_q;
  logic [7:0]  ireg_q, vec_q, lo_q, hi_q;
  logic        cnt_load, cnt_expired, ack_done, im0_take;
  logic [15:0] vlo_addr;

  intack_wait_cnt u_wait_cnt (
    .clk      (clk),
    .nreset   (nreset),
    .load     (cnt_load),
    .load_val (WAITS),
    .en       (state_q == ACK),
    .expired  (cnt_expired)
  );

`ifdef INTR_IM0_EN
  assign im0_take = im0_q;
  assign im0_op   = vec_q;
`else
  logic im0_unused;
  assign im0_unused = ^{im0_q, vec_q[0]};
  assign im0_take   = 1'b0;
  assign im0_op     = 8'h00;
`endif

  // bus_ready only counts once the forced wait states have elapsed
  assign ack_done = (state_q == ACK) && cnt_expired && bus_ready;
  assign vlo_addr = {ireg_q, vec_q[7:1], 1'b0};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      nmi_q   <= 1'b0;
      im2_q   <= 1'b0;
      im0_q   <= 1'b0;
      ireg_q  <= 8'h00;
      vec_q   <= 8'h00;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && instr_done) begin
        nmi_q  <= in_nmi;
        im2_q  <= im2;
        im0_q  <= !im1 && !im2;
        ireg_q <= i_reg;
      end
      if (ack_done) vec_q <= db;
      if ((state_q == VLO) && bus_ready) lo_q <= db;
      if ((state_q == VHI) && bus_ready) hi_q <= db;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    intack    = 1'b0;
    clr_iff1  = 1'b0;
    clr_iff2  = 1'b0;
    push_req  = 1'b0;
    rd_req    = 1'b0;
    rd_addr   = 16'h0000;
    pc_load   = 1'b0;
    pc_vec    = 16'h0000;
    im0_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_done && in_nmi) begin
          state_d = CLR;
        end else if (instr_done && in_intr) begin
          state_d  = ACK;
          cnt_load = 1'b1;
        end
      end
      ACK: begin
        intack = 1'b1;
        if (ack_done) state_d = CLR;
      end
      CLR: begin
        clr_iff1 = 1'b1;
        clr_iff2 = !nmi_q;   // NMI keeps the old IFF1 in IFF2
        if (!nmi_q && im0_take) begin
          im0_valid = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = PUSH;
        end
      end
      PUSH: begin
        push_req = 1'b1;
        if (push_done) state_d = (!nmi_q && im2_q) ? VLO : LOAD;
      end
      VLO: begin
        rd_req  = 1'b1;
        rd_addr = vlo_addr;
        if (bus_ready) state_d = VHI;
      end
      VHI: begin
        rd_req  = 1'b1;
        rd_addr = vlo_addr + 16'd1;
        if (bus_ready) state_d = LOAD;
      end
      LOAD: begin
        pc_load = 1'b1;
        pc_vec  = nmi_q ? NMI_VEC : (im2_q ? {hi_q, lo_q} : IM1_VEC);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign ctl_no_ints = busy;

endmodule

// File: tb/tb_intr_ack_seq.sv
// Randomized bench for intr_ack_seq: a reactive bus/push agent drives each sequence,
// and a per-sequence model derives expected counts, addresses and vectors from the rules.
module tb_intr_ack_seq;
  import intr_pkg::*;

  localparam int AW = ACK_WAITS_DEFAULT;

  logic        clk = 1'b0;
  logic        nreset, instr_done, in_nmi, in_intr, im1, im2, bus_ready, push_done;
  logic [7:0]  i_reg, db;
  logic        busy, ctl_no_ints, intack, clr_iff1, clr_iff2, push_req, rd_req, pc_load, im0_valid;
  logic [15:0] rd_addr, pc_vec;
  logic [7:0]  im0_op;
  logic [48:0] all_outs;

  int tests = 0;
  int fails = 0;

  int          o_busy, o_intack, o_clr1, o_clr2, o_push, o_rd, o_nrd, o_load, o_load_off;
  int          o_im0v, o_hs_err, o_idle_err, o_timeout;
  logic [15:0] o_addr0, o_addr1, o_pcvec;
  logic [7:0]  o_im0op;

  typedef struct {
    int          busy, intack, clr2, push, rd, nrd, load, load_off, im0v;
    logic [15:0] addr0, addr1, pcvec;
    logic [7:0]  im0op;
  } exp_t;

  intr_ack_seq #(.ACK_WAITS(AW)) dut (
    .clk(clk), .nreset(nreset), .instr_done(instr_done), .in_nmi(in_nmi), .in_intr(in_intr),
    .im1(im1), .im2(im2), .i_reg(i_reg), .db(db), .bus_ready(bus_ready), .push_done(push_done),
    .busy(busy), .ctl_no_ints(ctl_no_ints), .intack(intack), .clr_iff1(clr_iff1),
    .clr_iff2(clr_iff2), .push_req(push_req), .rd_req(rd_req), .rd_addr(rd_addr),
    .pc_load(pc_load), .pc_vec(pc_vec), .im0_op(im0_op), .im0_valid(im0_valid)
  );

  assign all_outs = {busy, ctl_no_ints, intack, clr_iff1, clr_iff2, push_req, rd_req,
                     rd_addr, pc_load, pc_vec, im0_op, im0_valid};

  always #5 clk = ~clk;

  // Expected outcome of one sequence, from the path rules and the agent's chosen delays.
  function automatic exp_t model(input bit nmi, m1, m2, input logic [7:0] ir, ackb, lo, hi,
                                 input int ack_dly, push_dly, rd_dly);
    exp_t e;
    bit   im0_path;
    e = '{default: 0};
`ifdef INTR_IM0_EN
    im0_path = !nmi && !m1 && !m2;
`else
    im0_path = 1'b0;
`endif
    if (nmi) begin
      e.push  = push_dly + 1;
      e.pcvec = 16'h0066;
      e.load  = 1;
      e.busy  = 1 + e.push + 1;
    end else if (im0_path) begin
      e.intack = AW + 1 + ack_dly;
      e.clr2   = 1;
      e.im0v   = 1;
      e.im0op  = ackb;
      e.busy   = e.intack + 1;
    end else begin
      e.intack = AW + 1 + ack_dly;
      e.clr2   = 1;
      e.push   = push_dly + 1;
      e.load   = 1;
      if (m2) begin
        e.nrd   = 2;
        e.rd    = 2 * (rd_dly + 1);
        e.addr0 = {ir, ackb[7:1], 1'b0};
        e.addr1 = e.addr0 + 16'd1;
        e.pcvec = {hi, lo};
      end else begin
        e.pcvec = 16'h0038;
      end
      e.busy = e.intack + 1 + e.push + e.rd + 1;
    end
    if (e.load != 0) e.load_off = e.busy;
    return e;
  endfunction

  // Launch one sequence, play bus/push agent with the given delays, record what the DUT did.
  task automatic drive_seq(input bit nmi, intr, m1, m2, input logic [7:0] ir, ackb, lo, hi,
                           input int ack_dly, push_dly, rd_dly);
    int          ack_n, push_n, rd_n;
    bit          done, push_pend, rd_pend;
    logic [15:0] last_addr;
    ack_n = 0; push_n = 0; rd_n = 0; done = 0; push_pend = 0; rd_pend = 0; last_addr = '0;
    o_busy = 0; o_intack = 0; o_clr1 = 0; o_clr2 = 0; o_push = 0; o_rd = 0; o_nrd = 0;
    o_load = 0; o_load_off = 0; o_im0v = 0; o_hs_err = 0; o_idle_err = 0; o_timeout = 0;
    o_addr0 = '0; o_addr1 = '0; o_pcvec = '0; o_im0op = '0;
    @(negedge clk);
    instr_done = 1; in_nmi = nmi; in_intr = intr; im1 = m1; im2 = m2; i_reg = ir;
    bus_ready = 0; push_done = 0;
    for (int off = 1; off <= 300 && !done; off++) begin
      @(negedge clk);
      instr_done = 0; bus_ready = 0; push_done = 0; db = 8'($urandom);
      in_nmi = 1'($urandom); in_intr = 1'($urandom);
      im1 = 1'($urandom); im2 = 1'($urandom); i_reg = 8'($urandom);
      if (!busy) begin
        done = 1;
      end else begin
        o_busy++;
        if (ctl_no_ints !== busy) o_hs_err++;
        if (push_pend && !push_req) o_hs_err++;
        if (rd_pend && (!rd_req || rd_addr !== last_addr)) o_hs_err++;
        if (clr_iff1) o_clr1++;
        if (clr_iff2) o_clr2++;
        if (pc_load) begin o_load++; o_pcvec = pc_vec; o_load_off = off; end
        if (im0_valid) begin o_im0v++; o_im0op = im0_op; end
        if (intack) begin
          ack_n++; o_intack++;
          if (ack_dly == 0 || ack_n >= AW + 1 + ack_dly) begin bus_ready = 1; db = ackb; end
        end else if (push_req) begin
          push_n++; o_push++;
          if (push_n > push_dly) push_done = 1;
        end else if (rd_req) begin
          if (!rd_pend) begin
            if (o_nrd == 0) o_addr0 = rd_addr; else o_addr1 = rd_addr;
            o_nrd++;
          end
          rd_n++; o_rd++;
          if (rd_n > rd_dly) begin bus_ready = 1; db = rd_addr[0] ? hi : lo; rd_n = 0; end
        end else begin
          bus_ready = 1'($urandom); push_done = 1'($urandom);
        end
        push_pend = push_req && !push_done;
        rd_pend   = rd_req && !bus_ready;
        last_addr = rd_addr;
      end
    end
    if (!done) o_timeout = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy) o_idle_err++;
      in_nmi = 1'($urandom); in_intr = 1'($urandom);
      bus_ready = 1'($urandom); push_done = 1'($urandom);
    end
    bus_ready = 0; push_done = 0;
  endtask

  task automatic test_reset();
    nreset = 0; instr_done = 1; in_nmi = 1; in_intr = 1; im1 = 0; im2 = 0;
    i_reg = 8'h00; db = 8'h00; bus_ready = 1; push_done = 1;
    repeat (3) @(negedge clk);
    tests++; if (all_outs !== '0) begin fails++; $display("FAIL reset_outs got %h want 0", all_outs); end
    nreset = 1; instr_done = 0; bus_ready = 0; push_done = 0;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_nmi();
    drive_seq(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tests++; if (o_clr1 !== 1) begin fails++; $display("FAIL nmi_clr1 got %0d want 1", o_clr1); end
    tests++; if (o_clr2 !== 0) begin fails++; $display("FAIL nmi_clr2 got %0d want 0", o_clr2); end
    tests++; if (o_intack !== 0) begin fails++; $display("FAIL nmi_intack got %0d want 0", o_intack); end
    tests++; if (o_pcvec !== 16'h0066) begin fails++; $display("FAIL nmi_pcvec got %h want 0066", o_pcvec); end
    tests++; if (o_load_off !== 3) begin fails++; $display("FAIL nmi_load_off got %0d want 3", o_load_off); end
  endtask

  task automatic test_im1();
    drive_seq(0, 1, 1, 0, 8'h55, 8'h77, 8'h00, 8'h00, 1, 0, 0);
    tests++; if (o_intack !== 4) begin fails++; $display("FAIL im1_intack got %0d want 4", o_intack); end
    tests++; if (o_clr1 !== 1 || o_clr2 !== 1) begin fails++; $display("FAIL im1_clr got %0d/%0d want 1/1", o_clr1, o_clr2); end
    tests++; if (o_pcvec !== 16'h0038) begin fails++; $display("FAIL im1_pcvec got %h want 0038", o_pcvec); end
  endtask

  task automatic test_im2();
    drive_seq(0, 1, 0, 1, 8'h12, 8'h35, 8'hCD, 8'hAB, 0, 0, 0);
    tests++; if (o_addr0 !== 16'h1234) begin fails++; $display("FAIL im2_addr_lo got %h want 1234", o_addr0); end
    tests++; if (o_addr1 !== 16'h1235) begin fails++; $display("FAIL im2_addr_hi got %h want 1235", o_addr1); end
    tests++; if (o_pcvec !== 16'hABCD) begin fails++; $display("FAIL im2_pcvec got %h want abcd", o_pcvec); end
    tests++; if (o_load_off !== AW + 6) begin fails++; $display("FAIL im2_load_off got %0d want %0d", o_load_off, AW + 6); end
  endtask

  task automatic test_simultaneous();
    drive_seq(1, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tests++; if (o_intack !== 0) begin fails++; $display("FAIL simul_nmi_intack got %0d want 0", o_intack); end
    tests++; if (o_pcvec !== 16'h0066) begin fails++; $display("FAIL simul_nmi_pcvec got %h want 0066", o_pcvec); end
    tests++; if (o_idle_err !== 0) begin fails++; $display("FAIL simul_idle got %0d want 0", o_idle_err); end
    drive_seq(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tests++; if (o_pcvec !== 16'h0038) begin fails++; $display("FAIL simul_int_pcvec got %h want 0038", o_pcvec); end
  endtask

  task automatic test_im0();
    drive_seq(0, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, 0);
`ifdef INTR_IM0_EN
    tests++; if (o_im0v !== 1 || o_im0op !== 8'hFF) begin fails++; $display("FAIL im0_op got %0d/%h want 1/ff", o_im0v, o_im0op); end
    tests++; if (o_push !== 0 || o_load !== 0) begin fails++; $display("FAIL im0_nopush got %0d/%0d want 0/0", o_push, o_load); end
`else
    tests++; if (o_im0v !== 0 || o_im0op !== 8'h00) begin fails++; $display("FAIL im0_off got %0d/%h want 0/00", o_im0v, o_im0op); end
    tests++; if (o_push !== 1 || o_pcvec !== 16'h0038) begin fails++; $display("FAIL im0_as_im1 got %0d/%h want 1/0038", o_push, o_pcvec); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    instr_done = 1; in_nmi = 1; in_intr = 0; push_done = 0; bus_ready = 0;
    @(negedge clk);
    instr_done = 0;
    @(negedge clk);
    tests++; if (push_req !== 1'b1) begin fails++; $display("FAIL rstmid_push got %b want 1", push_req); end
    nreset = 0;
    #1;
    tests++; if (all_outs !== '0) begin fails++; $display("FAIL rstmid_async got %h want 0", all_outs); end
    @(posedge clk); #1;
    tests++; if (all_outs !== '0) begin fails++; $display("FAIL rstmid_edge got %h want 0", all_outs); end
    @(negedge clk);
    nreset = 1; in_nmi = 1; in_intr = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle%0d busy got %b want 0", k, busy); end
    end
    drive_seq(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tests++; if (o_pcvec !== 16'h0066 || o_load_off !== 3) begin fails++; $display("FAIL rstmid_resume got %h@%0d want 0066@3", o_pcvec, o_load_off); end
  endtask

  task automatic test_random();
    exp_t       e;
    bit         nmi, intr, m1, m2;
    int         mode, ad, pd, rdl;
    logic [7:0] ir, ab, lo, hi;
    for (int i = 0; i < 40; i++) begin
      nmi  = ($urandom_range(0, 3) == 0);
      intr = nmi ? 1'($urandom) : 1'b1;
      mode = $urandom_range(0, 2);
      m1 = (mode == 1); m2 = (mode == 2);
      ir = 8'($urandom); ab = 8'($urandom); lo = 8'($urandom); hi = 8'($urandom);
      ad = $urandom_range(0, 3); pd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      e = model(nmi, m1, m2, ir, ab, lo, hi, ad, pd, rdl);
      drive_seq(nmi, intr, m1, m2, ir, ab, lo, hi, ad, pd, rdl);
      tests++; if (o_timeout !== 0) begin fails++; $display("FAIL rnd%0d timeout", i); end
      tests++; if (o_busy !== e.busy) begin fails++; $display("FAIL rnd%0d busy got %0d want %0d", i, o_busy, e.busy); end
      tests++; if (o_intack !== e.intack) begin fails++; $display("FAIL rnd%0d intack got %0d want %0d", i, o_intack, e.intack); end
      tests++; if (o_clr1 !== 1 || o_clr2 !== e.clr2) begin fails++; $display("FAIL rnd%0d clr got %0d/%0d want 1/%0d", i, o_clr1, o_clr2, e.clr2); end
      tests++; if (o_push !== e.push) begin fails++; $display("FAIL rnd%0d push got %0d want %0d", i, o_push, e.push); end
      tests++; if (o_rd !== e.rd || o_nrd !== e.nrd) begin fails++; $display("FAIL rnd%0d rd got %0d/%0d want %0d/%0d", i, o_rd, o_nrd, e.rd, e.nrd); end
      tests++; if (o_addr0 !== e.addr0 || o_addr1 !== e.addr1) begin fails++; $display("FAIL rnd%0d addr got %h/%h want %h/%h", i, o_addr0, o_addr1, e.addr0, e.addr1); end
      tests++; if (o_load !== e.load || o_load_off !== e.load_off) begin fails++; $display("FAIL rnd%0d load got %0d@%0d want %0d@%0d", i, o_load, o_load_off, e.load, e.load_off); end
      tests++; if (o_pcvec !== e.pcvec) begin fails++; $display("FAIL rnd%0d pc_vec got %h want %h", i, o_pcvec, e.pcvec); end
      tests++; if (o_im0v !== e.im0v || o_im0op !== e.im0op) begin fails++; $display("FAIL rnd%0d im0 got %0d/%h want %0d/%h", i, o_im0v, o_im0op, e.im0v, e.im0op); end
      tests++; if (o_hs_err !== 0) begin fails++; $display("FAIL rnd%0d handshake got %0d errors want 0", i, o_hs_err); end
      tests++; if (o_idle_err !== 0) begin fails++; $display("FAIL rnd%0d idle got %0d busy cycles want 0", i, o_idle_err); end
    end
  endtask

  initial begin
    test_reset();
    test_nmi();
    test_im1();
    test_im2();
    test_simultaneous();
    test_im0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/intr_ack_seq.md
# intr_ack_seq

Interrupt acknowledge sequencer for the CPU control path. It sits between the interrupt state unit (IFF1/IFF2, IM mode, pending NMI/INT flags) and the bus/PC datapath. At an instruction boundary it takes a pending NMI or maskable interrupt and runs the full acknowledge sequence: INTACK M1 cycle, IFF update, PC push, vector fetch and PC load. It masks further interrupt sampling until the sequence completes.

## Interface
- ACK_WAITS, 2: forced wait states inserted in the INTACK cycle (1..7)
- clk  in  1  system clock; all state changes on rising edge
- nreset  in  1  asynchronous, active-low reset
- instr_done  in  1  current instruction ends this cycle (next cycle would be M1)
- in_nmi  in  1  NMI pending (from interrupt state unit)
- in_intr  in  1  maskable INT pending and enabled
- im1, im2  in  1 each  interrupt mode; both 0 = IM0
- i_reg  in  8  I register (IM2 table page)
- db  in  8  data bus read value, valid when bus_ready=1
- bus_ready  in  1  current bus cycle completes this clock
- push_done  in  1  PC push (two writes) completed this clock
- busy  out  1  sequence active; stalls normal fetch
- ctl_no_ints  out  1  blocks interrupt re-sampling; equals busy
- intack  out  1  INTACK M1 cycle in progress (M1+IORQ)
- clr_iff1, clr_iff2  out  1 each  one-cycle IFF clear pulses
- push_req  out  1  request PC push; held until push_done
- rd_req  out  1  memory read request; held until bus_ready
- rd_addr  out  16  address for rd_req
- pc_load  out  1  one-cycle pulse loading pc_vec into PC
- pc_vec  out  16  new PC value, valid with pc_load
- im0_op  out  8  opcode captured during IM0 INTACK
- im0_valid  out  1  one-cycle pulse: execute im0_op as next instruction

## Operation
- States: IDLE, ACK, CLR, PUSH, VLO, VHI, LOAD.
- IDLE: if instr_done and in_nmi -> CLR (NMI path). Else if instr_done and in_intr -> ACK. NMI wins when both are pending. Without instr_done, nothing happens.
- ACK: intack=1. Count ACK_WAITS cycles, then wait for bus_ready. On bus_ready, latch db into a vector register, then -> CLR.
- CLR: one cycle. NMI path: clr_iff1=1, clr_iff2=0 (IFF2 keeps the old IFF1). INT path: clr_iff1=clr_iff2=1. Next state:
  - IM0 -> IDLE with im0_valid=1 and im0_op=latched byte.
  - Otherwise -> PUSH.
- PUSH: push_req=1 until push_done. Then IM2 -> VLO; NMI or IM1 -> LOAD.
- VLO: rd_req=1, rd_addr={i_reg, vec[7:1], 1'b0}. On bus_ready, latch low byte -> VHI.
- VHI: rd_req=1, rd_addr=(VLO address)+1, 16-bit wrap. On bus_ready, latch high byte -> LOAD.
- LOAD: one cycle with pc_load=1. pc_vec = 0x0066 (NMI), 0x0038 (IM1), or {hi,lo} (IM2). Then -> IDLE.
- NMI path never enters ACK and never reads db.
- Mode and i_reg are sampled on entry to ACK and held for the whole sequence. Changes mid-sequence are ignored.
- in_nmi rising during an INT sequence is not taken until the next instr_done after return to IDLE.

## Timing
- Reset: state=IDLE. All outputs 0, pc_vec=0, im0_op=0. Reset mid-sequence aborts immediately, with no partial pulses.
- Latency from the instr_done cycle (zero bus/push waits):
  - NMI: CLR at +1, PUSH at +2, LOAD at +3.
  - IM1: ACK +1..+ACK_WAITS+1, then CLR, PUSH, LOAD.
  - IM2: adds VLO and VHI, one cycle each.
- busy=1 from the cycle after instr_done through the LOAD cycle (or the IM0 CLR cycle) inclusive.
- Handshakes: push_req and rd_req hold stable until their completion input. rd_addr holds stable while rd_req=1. A completion input seen in a state not requesting it is ignored.

## Configuration
- INTR_IM0_EN defined: IM0 path as above (im0_op/im0_valid active).
- Not defined: IM0 is handled exactly as IM1 (push, vector 0x0038). The INTACK data byte is discarded. im0_valid and im0_op are tied to 0.

## Structure
- Shared package intr_pkg holds:
  - state enum intr_state_t
  - constants NMI_VEC=16'h0066 and IM1_VEC=16'h0038
  - ACK_WAITS default
- One sub-module: intack_wait_cnt. It is a 3-bit down-counter with load/expire, used in ACK.

## Test plan
- NMI only, instr_done pulse, push_done on first request: clr_iff1 pulse with clr_iff2=0; pc_load with pc_vec=0x0066 exactly 3 cycles after instr_done; intack never asserted.
- IM1 INT, ACK_WAITS=2, bus_ready 1 cycle late: intack high 4 cycles; both IFF clears; pc_vec=0x0038.
- IM2, i_reg=0x12, db=0x35 at ACK, table bytes 0xCD/0xAB: rd_addr 0x1234 then 0x1235; pc_vec=0xABCD.
- Simultaneous in_nmi and in_intr at instr_done: NMI path taken (no intack, pc_vec=0x0066); INT taken after the next instr_done.
- IM0, db=0xFF: im0_valid pulse with im0_op=0xFF, no push_req. With INTR_IM0_EN undefined: push then pc_vec=0x0038.
- nreset low during PUSH: all outputs 0 next edge; after release, idle until instr_done.
